// File: rtl/counter_pkg.sv
// Shared encodings for the counter family: mode select and count direction.
package counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/updown_mod_counter.sv
// General-purpose BITS-wide counter: up, down, bounce and hold modes with a
// programmable inclusive upper bound, wrap/saturate, parallel load and a registered tc.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int BITS    = 4,
  parameter int RST_VAL = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic [1:0]      mode,
  input  logic            sat,
  input  logic [BITS-1:0] max_val,
  output logic [BITS-1:0] Q,
  output logic            dir,
  output logic            tc
);

  localparam logic [BITS-1:0] RST_Q = RST_VAL[BITS-1:0];
  localparam logic [BITS-1:0] ZERO  = '0;
  localparam logic [BITS-1:0] ONE   = {{(BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0] q_r, q_nx;
  logic            dir_r, dir_nx;
  logic            tc_r, tc_nx;

  always_comb begin
    q_nx   = q_r;
    dir_nx = dir_r;
    tc_nx  = 1'b0;
    if (load) begin
      q_nx = (load_val > max_val) ? max_val : load_val;
    end else if (!en || mode == MODE_HOLD) begin
      q_nx = q_r;
    end else if (q_r > max_val) begin
      // Bound was lowered under us: pull back into range without a terminal event.
      q_nx = (mode == MODE_UP && !sat) ? ZERO : max_val;
      if (mode == MODE_UP)   dir_nx = DIR_UP;
      if (mode == MODE_DOWN) dir_nx = DIR_DN;
    end else begin
      case (mode)
        MODE_UP: begin
          dir_nx = DIR_UP;
          if (q_r == max_val) begin
            q_nx  = sat ? q_r : ZERO;
            tc_nx = 1'b1;
          end else begin
            q_nx = q_r + ONE;
          end
        end
        MODE_DOWN: begin
          dir_nx = DIR_DN;
          if (q_r == ZERO) begin
            q_nx  = sat ? q_r : max_val;
            tc_nx = 1'b1;
          end else begin
            q_nx = q_r - ONE;
          end
        end
        MODE_BOUNCE: begin
          if (max_val == ZERO) begin
            q_nx  = ZERO;
            tc_nx = 1'b1;
          end else if (dir_r == DIR_UP) begin
            if (q_r == max_val) begin
              q_nx   = max_val - ONE;
              dir_nx = DIR_DN;
              tc_nx  = 1'b1;
            end else begin
              q_nx = q_r + ONE;
            end
          end else begin
            if (q_r == ZERO) begin
              q_nx   = ONE;
              dir_nx = DIR_UP;
              tc_nx  = 1'b1;
            end else begin
              q_nx = q_r - ONE;
            end
          end
        end
        default: q_nx = q_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r   <= RST_Q;
      dir_r <= DIR_UP;
      tc_r  <= 1'b0;
    end else begin
      q_r   <= q_nx;
      dir_r <= dir_nx;
      tc_r  <= tc_nx;
    end
  end

  assign Q   = q_r;
  assign dir = dir_r;
  assign tc  = tc_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: directed walk through the main scenarios, then
// randomized traffic against an integer reference model with an expected queue.
module tb_updown_mod_counter;

  localparam int BITS    = 4;
  localparam int RST_VAL = 0;
  localparam int W       = BITS + 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            en;
  logic            load;
  logic [BITS-1:0] load_val;
  logic [1:0]      mode;
  logic            sat;
  logic [BITS-1:0] max_val;
  logic [BITS-1:0] q;
  logic            dir;
  logic            tc;

  int errors = 0;
  int checks = 0;
  int m_q, m_dir, m_tc;
  logic [W-1:0] exp_q[$];

  updown_mod_counter #(.BITS(BITS), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .sat(sat), .max_val(max_val), .Q(q), .dir(dir), .tc(tc)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [BITS-1:0] qv;
    qv = m_q[BITS-1:0];
    return {m_tc[0], m_dir[0], qv};
  endfunction

  // Reference: Q lives in 0..max, computed with plain integer arithmetic.
  task automatic model_edge();
    int mx, lv, md;
    mx = int'(max_val);
    lv = int'(load_val);
    md = int'(mode);
    if (load) begin
      m_q  = (lv < mx) ? lv : mx;
      m_tc = 0;
    end else if (!en || md == 3) begin
      m_tc = 0;
    end else if (m_q > mx) begin
      m_q  = (md == 0 && !sat) ? 0 : mx;
      m_tc = 0;
      if (md == 0) m_dir = 0;
      if (md == 1) m_dir = 1;
    end else if (md == 0) begin
      m_dir = 0;
      m_tc  = (m_q == mx) ? 1 : 0;
      if (m_q < mx) m_q = m_q + 1;
      else if (!sat) m_q = 0;
    end else if (md == 1) begin
      m_dir = 1;
      m_tc  = (m_q == 0) ? 1 : 0;
      if (m_q > 0) m_q = m_q - 1;
      else if (!sat) m_q = mx;
    end else begin
      if (mx == 0) begin
        m_q  = 0;
        m_tc = 1;
      end else begin
        int nxt;
        nxt  = (m_dir == 0) ? m_q + 1 : m_q - 1;
        m_tc = 0;
        if (nxt > mx || nxt < 0) begin
          m_dir = 1 - m_dir;
          nxt   = (m_dir == 0) ? m_q + 1 : m_q - 1;
          m_tc  = 1;
        end
        m_q = nxt;
      end
    end
  endtask

  task automatic model_reset();
    m_q   = RST_VAL;
    m_dir = 0;
    m_tc  = 0;
  endtask

  // One clock: update model at the edge, compare outputs 1 time unit later.
  task automatic step(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    exp_q.push_back(pack_model());
    #1;
    e = exp_q.pop_front();
    check({tag, ".q"},   32'(q),   32'(e[BITS-1:0]));
    check({tag, ".dir"}, 32'(dir), 32'(e[BITS]));
    check({tag, ".tc"},  32'(tc),  32'(e[BITS+1]));
  endtask

  task automatic drive(input logic l, input logic [BITS-1:0] lv, input logic e,
                       input logic [1:0] md, input logic s, input logic [BITS-1:0] mx);
    load = l; load_val = lv; en = e; mode = md; sat = s; max_val = mx;
  endtask

  initial begin
    reset_n = 1'b0;
    model_reset();
    drive(1'b0, 4'd0, 1'b1, 2'b00, 1'b0, 4'd15);
    #1;
    check("rst_async.q", 32'(q), 32'(RST_VAL));
    for (int i = 0; i < 5; i++) step("rst");

    // 1: free-running up count with wrap at 15
    #1 reset_n = 1'b1;
    step("t1_first");
    check("t1_first_is_1", 32'(q), 32'd1);
    for (int i = 0; i < 14; i++) step("t1");
    check("t1_at_15", 32'(q), 32'd15);
    step("t1_wrap");
    check("t1_wrap_q", 32'(q), 32'd0);
    check("t1_wrap_tc", 32'(tc), 32'd1);
    step("t1_after");
    check("t1_tc_one_cycle", 32'(tc), 32'd0);

    // 2: saturating up to 9
    drive(1'b1, 4'd0, 1'b1, 2'b00, 1'b1, 4'd9);
    step("t2_load");
    load = 1'b0;
    for (int i = 0; i < 12; i++) step("t2");
    check("t2_held_q", 32'(q), 32'd9);
    check("t2_held_tc", 32'(tc), 32'd1);

    // 3: down with wrap to 9
    drive(1'b1, 4'd2, 1'b1, 2'b01, 1'b0, 4'd9);
    step("t3_load");
    check("t3_load_q", 32'(q), 32'd2);
    load = 1'b0;
    step("t3"); step("t3");
    step("t3_wrap");
    check("t3_wrap_q", 32'(q), 32'd9);
    check("t3_wrap_tc", 32'(tc), 32'd1);
    step("t3_after");
    check("t3_after_q", 32'(q), 32'd8);

    // 4: bounce between 0 and 3, entered with Q=0 dir=0
    drive(1'b0, 4'd0, 1'b1, 2'b00, 1'b0, 4'd3);
    step("t4_prep");
    check("t4_prep_q", 32'(q), 32'd0);
    mode = 2'b10;
    step("t4"); step("t4"); step("t4");
    step("t4_top");
    check("t4_top_q", 32'(q), 32'd2);
    check("t4_top_tc", 32'(tc), 32'd1);
    check("t4_top_dir", 32'(dir), 32'd1);
    step("t4"); step("t4");
    step("t4_bot");
    check("t4_bot_q", 32'(q), 32'd1);
    check("t4_bot_tc", 32'(tc), 32'd1);
    check("t4_bot_dir", 32'(dir), 32'd0);

    // 5: load clamps to bound; lowered bound pulls Q back without tc
    drive(1'b1, 4'd12, 1'b1, 2'b00, 1'b0, 4'd9);
    step("t5_load");
    check("t5_clamp_q", 32'(q), 32'd9);
    drive(1'b0, 4'd0, 1'b1, 2'b00, 1'b0, 4'd5);
    step("t5_oor");
    check("t5_oor_q", 32'(q), 32'd0);
    check("t5_oor_tc", 32'(tc), 32'd0);

    // 6: asynchronous reset between edges, load ignored
    drive(1'b1, 4'd7, 1'b1, 2'b00, 1'b0, 4'd15);
    step("t6_load");
    load = 1'b0;
    #2;
    reset_n = 1'b0;
    load = 1'b1;
    load_val = 4'd5;
    #1;
    check("t6_async_q", 32'(q), 32'(RST_VAL));
    check("t6_async_tc", 32'(tc), 32'd0);
    step("t6_in_rst");
    #1 reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 9) != 0);
      mode     = 2'($urandom_range(0, 3));
      sat      = 1'($urandom_range(0, 1));
      load_val = BITS'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: max_val = '0;
          1: max_val = '1;
          default: max_val = BITS'($urandom_range(0, 15));
        endcase
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised successor to the plain up counter: a BITS-wide counter with up, down, bounce (up/down) and hold modes.
- Programmable inclusive upper bound; wrap or saturate at the bounds; synchronous parallel load; count enable.
- Registered terminal-count pulse for cascading or driving timers.
- Sits beside the basic counter blocks as the general-purpose counter for the codebase.

Parameters:
BITS, 4, counter width; legal range 2..32.
RST_VAL, 0, value of Q after reset; must be <= (2**BITS)-1.

Ports:
clk       input   1     rising-edge clock
reset_n   input   1     asynchronous active-low reset
en        input   1     count enable
load      input   1     synchronous load strobe; priority over en
load_val  input   BITS  value loaded when load=1
mode      input   2     00 up, 01 down, 10 bounce, 11 hold
sat       input   1     1 = saturate at bounds, 0 = wrap (ignored in bounce)
max_val   input   BITS  inclusive upper bound of the count range
Q         output  BITS  registered count
dir       output  1     registered direction: 0 up, 1 down
tc        output  1     registered terminal-count pulse

Behaviour:
- Reset: reset_n=0 asynchronously forces Q=RST_VAL, dir=0, tc=0. Release is synchronous to the next clk edge; counting starts on the first edge with reset_n=1.
- Edge priority, highest first: load, then en=0 or mode=11, then counting.
- Load: Q <= min(load_val, max_val); dir and tc are unchanged in value, except tc <= 0.
- Hold (en=0 or mode=11): Q and dir hold; tc <= 0.
- Out of range (Q > max_val, e.g. max_val lowered mid-run) on a counting edge:
  - up with sat=0: Q <= 0.
  - all other cases: Q <= max_val.
  - tc <= 0.
- Up (mode 00): dir <= 0.
  - Q < max_val: Q <= Q+1, tc <= 0.
  - Q == max_val: Q <= 0 (sat=0) or Q holds (sat=1); tc <= 1.
- Down (mode 01): dir <= 1.
  - Q > 0: Q <= Q-1, tc <= 0.
  - Q == 0: Q <= max_val (sat=0) or Q holds at 0 (sat=1); tc <= 1.
- Bounce (mode 10): dir is kept from the previous cycle on entry.
  - dir=0, Q < max_val: Q <= Q+1.
  - dir=0, Q == max_val: Q <= max_val-1, dir <= 1, tc <= 1.
  - dir=1, Q > 0: Q <= Q-1.
  - dir=1, Q == 0: Q <= 1, dir <= 0, tc <= 1.
  - max_val == 0: Q stays 0, dir unchanged, tc <= 1 every enabled edge.
- tc timing: tc is high for exactly the cycle after a terminal event and rises together with the wrapped, held or reversed Q. Consecutive terminal events (saturated hold, max_val=0) keep tc high continuously.
- Width rules: all arithmetic is BITS wide, with no carry out beyond tc. max_val = 2**BITS-1 gives a full binary range. Inputs are sampled only at the clk edge.
- Mode change mid-count takes effect on the next edge, with no flush cycle.
- Reset asserted mid-operation overrides load and en immediately (asynchronous).

Decomposition:
- Shared package counter_pkg holds:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11;
  - direction constants DIR_UP=1'b0, DIR_DN=1'b1.
- Single module. Next-state logic is one combinational block feeding one register process for Q, dir and tc; no sub-module is warranted.

Test Plan (BITS=4, RST_VAL=0):
1. reset_n=0 for 5 clk edges, then released with en=1, mode=00, sat=0, max_val=15. Q=0, dir=0, tc=0 during reset; Q=1 after the first edge post-release; Q wraps 15->0 with tc=1 for one cycle only.
2. max_val=9, mode=00, sat=1, counting from 0. Q reaches 9 and holds; tc stays high while held; Q does not wrap.
3. mode=01, sat=0, max_val=9, load=1 with load_val=2. Q=2, then 1, 0, 9 (tc=1 with Q=9), 8.
4. mode=10, max_val=3, from Q=0, dir=0. Q sequence 1,2,3,2,1,0,1 with dir toggling; tc=1 with Q=2 (first time) and with Q=1 (second time).
5. load=1, load_val=12, max_val=9. Q=9. Then with Q=9 and max_val lowered to 5, mode=00, sat=0: Q=0 next edge, tc=0.
6. reset_n pulsed low asynchronously mid-count at Q=7, between edges. Q=0 immediately, before the next clk edge; load=1 in the same cycle is ignored.
